// File: rtl/bexkat1_pkg.sv
// Shared definitions for the bexkat1 instruction-side blocks.
package bexkat1_pkg;

   localparam int unsigned WORD_BYTES = 4;

   // One buffered instruction word together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] word;
      logic [31:0] adr;
   } fetch_entry_t;

   typedef enum logic {
      PF_RUN,
      PF_FLUSH
   } prefetch_state_t;

endpackage

// File: rtl/ins_prefetch_if.sv
// Instruction-side pipelined Wishbone read port (prefetcher is the master).
interface ins_prefetch_if;

   logic [31:0] bus_adr_o;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_stall_i;
   logic        bus_ack_i;
   logic [31:0] bus_dat_i;

   modport master (
      output bus_adr_o, bus_cyc_o, bus_stb_o,
      input  bus_stall_i, bus_ack_i, bus_dat_i
   );

   modport slave (
      input  bus_adr_o, bus_cyc_o, bus_stb_o,
      output bus_stall_i, bus_ack_i, bus_dat_i
   );

endinterface

// File: rtl/ins_prefetch_sync_fifo.sv
// Small synchronous FIFO with a flop-based head; clear wins over push/pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_pop;

   // Pointer/count/storage update; pop on an empty FIFO is ignored.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && (count_q != '0);
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push_i) - CW'(do_pop);
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetch queue: issues sequential pipelined reads and buffers
// returned words for ifetch; a redirect flushes and discards in-flight reads.
module ins_prefetch
   import bexkat1_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 pc_set_i,
   input  logic [31:0]          pc_i,
   ins_prefetch_if.master       bus,
   output logic [31:0]          word_o,
   output logic [31:0]          word_adr_o,
   output logic                 valid_o,
   input  logic                 pop_i
);

   localparam int unsigned CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [31:0] RST_ADR = RESET_PC & ~32'h3;

   prefetch_state_t state_q, state_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     tag_q, tag_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;

   logic            stb;
   logic            accept;
   logic            ack_drop;
   logic            ack_push;
   logic            fifo_clear;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    fifo_din;
   fetch_entry_t    fifo_head;

   // Credit check, ack routing, redirect handling and next-state logic.
   always_comb begin
      state_d       = state_q;
      adr_d         = adr_q;
      tag_d         = tag_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      fifo_clear    = 1'b0;
      stb           = 1'b0;

      // Only registered occupancy is used, so a same-cycle pop frees no credit.
      if ((state_q == PF_RUN) && !rst_i &&
          (({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_W)) begin
         stb = 1'b1;
      end
      accept   = stb && !bus.bus_stall_i;
      ack_drop = bus.bus_ack_i && (discard_q != '0);
      ack_push = bus.bus_ack_i && (discard_q == '0) && (outstanding_q != '0);

      if (accept) begin
         adr_d = adr_q + 32'(WORD_BYTES);
      end
      if (ack_push) begin
         tag_d = tag_q + 32'(WORD_BYTES);
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(ack_push);
      discard_d     = discard_q - CW'(ack_drop);

      if (pc_set_i) begin
         // Everything still owed by the bus becomes discard credit, including
         // a request accepted this cycle; an ack this cycle settles one of them.
         fifo_clear    = 1'b1;
         adr_d         = pc_i & ~32'h3;
         tag_d         = pc_i & ~32'h3;
         discard_d     = discard_q + outstanding_q + CW'(accept)
                         - CW'(ack_drop || ack_push);
         outstanding_d = '0;
         state_d       = (discard_d != '0) ? PF_FLUSH : PF_RUN;
      end else if ((state_q == PF_FLUSH) && (discard_d == '0)) begin
         state_d = PF_RUN;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= PF_RUN;
         adr_q         <= RST_ADR;
         tag_q         <= RST_ADR;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         adr_q         <= adr_d;
         tag_q         <= tag_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assign fifo_din = '{word: bus.bus_dat_i, adr: tag_q};

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (ack_push),
      .pop_i   (pop_i),
      .clear_i (fifo_clear),
      .din_i   (fifo_din),
      .head_o  (fifo_head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign bus.bus_adr_o = adr_q;
   assign bus.bus_stb_o = stb;
   assign bus.bus_cyc_o = stb || (outstanding_q != '0) || (discard_q != '0);

   assign valid_o    = !fifo_empty;
   assign word_o     = fifo_head.word;
   assign word_adr_o = fifo_head.adr;

endmodule

// File: tb/tb_ins_prefetch.sv
// Directed vector bench for ins_prefetch with a 1-cycle-ack Wishbone slave model.
module tb_ins_prefetch;

   logic        clk;
   logic        rst;
   logic        pc_set;
   logic [31:0] pc;
   logic        pop;
   logic [31:0] word;
   logic [31:0] word_adr;
   logic        valid;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] slv_q[$];

   ins_prefetch_if bif ();

   ins_prefetch #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .pc_set_i   (pc_set),
      .pc_i       (pc),
      .bus        (bif),
      .word_o     (word),
      .word_adr_o (word_adr),
      .valid_o    (valid),
      .pop_i      (pop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          chk;
      bit          rst;
      bit          ps;
      logic [31:0] pc;
      bit          st;
      bit          po;
      bit          ae;
      bit          e_cyc;
      bit          e_stb;
      logic [31:0] e_adr;
      bit          e_val;
      logic [31:0] e_wadr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit c, r, ps, input logic [31:0] p,
                               input bit st, po, ae, ecyc, estb,
                               input logic [31:0] eadr, input bit ev,
                               input logic [31:0] ewa);
      vec_t v;
      v.chk = c;  v.rst = r;  v.ps = ps;  v.pc = p;
      v.st = st;  v.po = po;  v.ae = ae;
      v.e_cyc = ecyc;  v.e_stb = estb;  v.e_adr = eadr;
      v.e_val = ev;  v.e_wadr = ewa;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave acks the oldest pending request when enabled; data is ~address.
   task automatic drive(input bit r, ps, input logic [31:0] p, input bit st, po, ae);
      rst    = r;
      pc_set = ps;
      pc     = p;
      pop    = po;
      bif.bus_stall_i = st;
      if (ae && (slv_q.size() > 0)) begin
         bif.bus_ack_i = 1'b1;
         bif.bus_dat_i = ~slv_q[0];
      end else begin
         bif.bus_ack_i = 1'b0;
         bif.bus_dat_i = '0;
      end
      #1;
   endtask

   task automatic tick(output bit accepted);
      bit          a_ack;
      logic [31:0] a_adr;
      accepted = (bif.bus_stb_o === 1'b1) && (bif.bus_stall_i == 1'b0);
      a_ack    = bif.bus_ack_i;
      a_adr    = bif.bus_adr_o;
      @(posedge clk);
      if (a_ack) void'(slv_q.pop_front());
      if (accepted) slv_q.push_back(a_adr);
      @(negedge clk);
   endtask

   initial begin
      bit          acc;
      int unsigned n_acc;
      int unsigned budget;
      string       tag;

      rst = 1'b1;  pc_set = 1'b0;  pc = '0;  pop = 1'b0;
      bif.bus_stall_i = 1'b0;  bif.bus_ack_i = 1'b0;  bif.bus_dat_i = '0;

      //                chk rst ps pc            st po ae  cyc stb adr           val wadr
      // reset, then streaming with a pop every cycle
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h4,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h8,        1, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'hC,        1, 32'h4));
      // stop popping: FIFO fills to 4, stb drops
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h10,       1, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h14,       1, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h18,       1, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  0, 0, 32'h18,       1, 32'h8));
      // one pop frees one credit, seen the following cycle
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  0, 0, 32'h18,       1, 32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h18,       1, 32'hC));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h1C,       1, 32'hC));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 0, 32'h1C,       1, 32'hC));
      // 5-cycle stall: address held
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1, 1,  1, 1, 32'h1C,       1, 32'h10));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1,  1, 1, 32'h1C,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1,  1, 1, 32'h1C,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1,  1, 1, 32'h1C,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 1,  1, 1, 32'h1C,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h1C,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h20,       1, 32'h14));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h24,       1, 32'h18));
      // build 3 in flight, then redirect to 0x1003
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0,  1, 1, 32'h28,       1, 32'h1C));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 1, 32'h2C,       1, 32'h20));
      vecs.push_back(mk(1, 0, 1, 32'h1003,     0, 0, 0,  1, 0, 32'h30,       1, 32'h20));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h1000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h1000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h1000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h1000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h1004,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 1, 32'h1008,     1, 32'h1000));
      // redirect with same-cycle ack, accept and pop; second redirect in FLUSH
      vecs.push_back(mk(1, 0, 1, 32'h2000,     0, 1, 1,  1, 1, 32'h100C,     1, 32'h1000));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h2000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h3004,     0, 0, 1,  1, 0, 32'h2000,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h3004,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 1, 32'h3004,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h3008,     0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,  1, 1, 32'h300C,     1, 32'h3004));
      // reset with 2 outstanding, late acks during reset
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0,  1, 0, 32'h3010,     1, 32'h3004));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1,  0, 0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1,  0, 0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h4,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h8,        1, 32'h0));
      // redirect near the top of the address space, then wrap
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFF8, 0, 0, 1, 1, 1, 32'hC,        1, 32'h4));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'hFFFF_FFF8, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'hFFFF_FFF8, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'hFFFF_FFFC, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1,  1, 1, 32'h0,        1, 32'hFFFF_FFF8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h4,        1, 32'hFFFF_FFF8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1,  1, 1, 32'h8,        1, 32'hFFFF_FFFC));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0,  1, 1, 32'hC,        1, 32'h0));

      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ps, vecs[i].pc, vecs[i].st, vecs[i].po, vecs[i].ae);
         if (vecs[i].chk) begin
            tag = $sformatf("v%0d", i);
            cmp({tag, ".cyc"}, 32'(bif.bus_cyc_o), 32'(vecs[i].e_cyc));
            cmp({tag, ".stb"}, 32'(bif.bus_stb_o), 32'(vecs[i].e_stb));
            cmp({tag, ".adr"}, bif.bus_adr_o, vecs[i].e_adr);
            cmp({tag, ".valid"}, 32'(valid), 32'(vecs[i].e_val));
            if (vecs[i].e_val) begin
               cmp({tag, ".word_adr"}, word_adr, vecs[i].e_wadr);
               cmp({tag, ".word"}, word, ~vecs[i].e_wadr);
            end
         end
         tick(acc);
      end

      // No pops from reset: exactly 4 requests accepted, then the queue idles full.
      drive(1, 0, 32'h0, 0, 0, 1);
      tick(acc);
      drive(1, 0, 32'h0, 0, 0, 1);
      tick(acc);
      n_acc  = 0;
      budget = 0;
      drive(0, 0, 32'h0, 0, 0, 1);
      while (!(valid === 1'b1 && bif.bus_cyc_o === 1'b0) && budget < 20) begin
         tick(acc);
         if (acc) n_acc++;
         budget++;
         drive(0, 0, 32'h0, 0, 0, 1);
      end
      cmp("fill.timeout", 32'(budget < 20), 32'd1);
      cmp("fill.accepts", n_acc, 32'd4);
      cmp("fill.stb", 32'(bif.bus_stb_o), 32'd0);
      cmp("fill.adr", bif.bus_adr_o, 32'h10);
      cmp("fill.word_adr", word_adr, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick(acc);
         if (acc) n_acc++;
         drive(0, 0, 32'h0, 0, 0, 1);
      end
      cmp("fill.hold_accepts", n_acc, 32'd4);
      drive(0, 0, 32'h0, 0, 1, 1);
      cmp("pop1.stb_same", 32'(bif.bus_stb_o), 32'd0);
      tick(acc);
      drive(0, 0, 32'h0, 0, 0, 1);
      cmp("pop1.stb_next", 32'(bif.bus_stb_o), 32'd1);
      cmp("pop1.adr_next", bif.bus_adr_o, 32'h10);
      cmp("pop1.word_adr", word_adr, 32'h4);
      tick(acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
